// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, divider state encoding and the
// opcode that routes an ALU operation to the sequential divider.
package alu_pkg;

    // Operand/result width of the ALU datapath.
    localparam int WIDTH = 32;

    // Iteration counter width; 2**CNT_W must exceed WIDTH.
    localparam int CNT_W = 6;

    // Divider control states, kept as plain constants for older tooling.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DZ   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // ALU control opcodes for the two sequential units.
    localparam logic [3:0] ALU_OP_MUL = 4'b1000;
    localparam logic [3:0] ALU_OP_DIV = 4'b1001;

endpackage

// File: rtl/sub_33b.sv
// Structural ripple-borrow subtractor, diff = a - b, built bit by bit in the
// same style as the ALU adder. The sign output is the MSB of the difference,
// which the divider uses as its restore decision.
module sub_33b #(
    parameter int N = alu_pkg::WIDTH + 1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         sign,
    output logic         borrow_out
);

    logic [N:0] borrow;

    assign borrow[0] = 1'b0;

    // One full-subtractor cell per bit, borrow rippling from LSB to MSB.
    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_bit
            logic axb;
            assign axb           = a[i] ^ b[i];
            assign diff[i]       = axb ^ borrow[i];
            assign borrow[i + 1] = (~a[i] & b[i]) | (~axb & borrow[i]);
        end
    endgenerate

    assign sign       = diff[N-1];
    assign borrow_out = borrow[N];

endmodule

// File: rtl/seq_divider_32b.sv
// Sequential unsigned restoring divider. One quotient bit is produced per
// clock; a start/busy/done handshake frames each operation. Division by zero
// short-circuits to an all-ones quotient with the dividend as remainder.
module seq_divider_32b #(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int CNT_W = alu_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    import alu_pkg::S_IDLE;
    import alu_pkg::S_RUN;
    import alu_pkg::S_DZ;
    import alu_pkg::S_DONE;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   a_shift;
    logic [WIDTH-1:0] q_shift;
    logic [WIDTH:0]   t_val;
    logic             t_sign;
    logic             accept;
    logic             sub_borrow_unused;
    logic             a_msb_unused;

    // {A,Q} shifted left by one. A is always below M between iterations, so
    // its top bit is zero and drops out of the shift.
    assign a_shift      = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign q_shift      = {q_q[WIDTH-2:0], 1'b0};
    assign a_msb_unused = a_q[WIDTH];

    // Trial subtraction of the divisor from the shifted partial remainder.
    sub_33b #(
        .N(WIDTH + 1)
    ) u_sub (
        .a          (a_shift),
        .b          ({1'b0, m_q}),
        .diff       (t_val),
        .sign       (t_sign),
        .borrow_out (sub_borrow_unused)
    );

    // A new request is only honoured when the unit is not iterating.
    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Next-state and datapath control for the divider FSM.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        q_d         = q_q;
        m_d         = m_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;

        if (accept) begin
            a_d     = '0;
            q_d     = dividend;
            m_d     = divisor;
            cnt_d   = '0;
            dz_d    = 1'b0;
            state_d = (divisor != '0) ? S_RUN : S_DZ;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_RUN: begin
                    if (!t_sign) begin
                        a_d = t_val;
                        q_d = {q_shift[WIDTH-1:1], 1'b1};
                    end else begin
                        a_d = a_shift;
                        q_d = q_shift;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d     = S_DONE;
                        quotient_d  = q_d;
                        remainder_d = a_d[WIDTH-1:0];
                    end
                end
                S_DZ: begin
                    quotient_d  = '1;
                    remainder_d = q_q;
                    dz_d        = 1'b1;
                    state_d     = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, operand and result registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            m_q         <= m_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dz_q;
    assign busy        = (state_q == S_RUN) || (state_q == S_DZ);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_divider_32b.sv
// Directed bench for the sequential divider with hand-computed results,
// latency checks, busy-time start rejection, back-to-back start and abort.
module tb_seq_divider_32b;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int vectorCount = 0;
    int missCount   = 0;

    seq_divider_32b dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    // 10 ns free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Present operands with start on a falling edge; the following rising
    // edge accepts them. Start drops just after that edge unless held.
    task automatic applyStimulus(input logic [31:0] dvd, input logic [31:0] dvs,
                                 input bit holdStart);
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clk);
        #1;
        if (!holdStart) start = 1'b0;
    endtask

    // Count cycles after acceptance until done is seen (cycle 1 is the one
    // right after the accepting edge), also counting cycles with busy high.
    task automatic waitDone(input int startCycles, output int cycles, output int busyCycles);
        cycles     = startCycles;
        busyCycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (busy) busyCycles++;
        end while (!done && cycles < 200);
    endtask

    int lat;
    int busyCnt;
    int doneSeen;

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_quotient", quotient, 32'd0);
        checkOutput("rst_remainder", remainder, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_dz", {31'd0, div_by_zero}, 32'd0);
        reset = 1'b0;

        // 100 / 7
        applyStimulus(32'd100, 32'd7, 1'b0);
        waitDone(0, lat, busyCnt);
        checkOutput("100/7 latency", lat, 32'd33);
        checkOutput("100/7 busy_cycles", busyCnt, 32'd32);
        checkOutput("100/7 quotient", quotient, 32'd14);
        checkOutput("100/7 remainder", remainder, 32'd2);
        checkOutput("100/7 dz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        checkOutput("100/7 done_one_cycle", {31'd0, done}, 32'd0);
        checkOutput("100/7 quotient_held", quotient, 32'd14);

        // Full-scale dividend
        applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0);
        waitDone(0, lat, busyCnt);
        checkOutput("max/1 quotient", quotient, 32'hFFFF_FFFF);
        checkOutput("max/1 remainder", remainder, 32'd0);

        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        waitDone(0, lat, busyCnt);
        checkOutput("max/max quotient", quotient, 32'd1);
        checkOutput("max/max remainder", remainder, 32'd0);

        // Divide by zero
        applyStimulus(32'd5, 32'd0, 1'b0);
        waitDone(0, lat, busyCnt);
        checkOutput("5/0 latency", lat, 32'd2);
        checkOutput("5/0 busy_cycles", busyCnt, 32'd1);
        checkOutput("5/0 dz", {31'd0, div_by_zero}, 32'd1);
        checkOutput("5/0 quotient", quotient, 32'hFFFF_FFFF);
        checkOutput("5/0 remainder", remainder, 32'd5);

        applyStimulus(32'd9, 32'd4, 1'b0);
        checkOutput("9/4 dz_cleared", {31'd0, div_by_zero}, 32'd0);
        waitDone(0, lat, busyCnt);
        checkOutput("9/4 dz", {31'd0, div_by_zero}, 32'd0);
        checkOutput("9/4 quotient", quotient, 32'd2);
        checkOutput("9/4 remainder", remainder, 32'd1);

        // Dividend below divisor, with a start pulse while busy
        applyStimulus(32'd3, 32'd10, 1'b0);
        repeat (5) @(negedge clk);
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        waitDone(6, lat, busyCnt);
        checkOutput("3/10 latency", lat, 32'd33);
        checkOutput("3/10 quotient", quotient, 32'd0);
        checkOutput("3/10 remainder", remainder, 32'd3);

        // Back-to-back: start held through DONE; operands change while busy
        applyStimulus(32'd1000, 32'd33, 1'b1);
        @(negedge clk);
        dividend = 32'd500;
        divisor  = 32'd7;
        waitDone(1, lat, busyCnt);
        checkOutput("1000/33 latency", lat, 32'd33);
        checkOutput("1000/33 quotient", quotient, 32'd30);
        checkOutput("1000/33 remainder", remainder, 32'd10);
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(0, lat, busyCnt);
        checkOutput("500/7 b2b_latency", lat, 32'd33);
        checkOutput("500/7 quotient", quotient, 32'd71);
        checkOutput("500/7 remainder", remainder, 32'd3);

        // Abort mid-operation
        applyStimulus(32'd77, 32'd3, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort quotient", quotient, 32'd0);
        checkOutput("abort remainder", remainder, 32'd0);
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) doneSeen++;
        end
        checkOutput("abort no_done", doneSeen, 32'd0);

        applyStimulus(32'd77, 32'd3, 1'b0);
        waitDone(0, lat, busyCnt);
        checkOutput("77/3 latency", lat, 32'd33);
        checkOutput("77/3 quotient", quotient, 32'd25);
        checkOutput("77/3 remainder", remainder, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
